// File: rtl/calendar_pkg.sv
// calendar_pkg: FSM encoding, field indices, o_sel codes, field limits and the
// days-per-month table shared by the calendar controller and its testbench-facing interface.
package calendar_pkg;

   typedef logic [5:0]  fld_vec_t;
   typedef logic [2:0]  sel_t;
   typedef logic [11:0] year_t;

   // Bit positions in o_inc / o_wrap: {year, month, day, hour, min, sec}
   localparam int FLD_SEC   = 0;
   localparam int FLD_MIN   = 1;
   localparam int FLD_HOUR  = 2;
   localparam int FLD_DAY   = 3;
   localparam int FLD_MONTH = 4;
   localparam int FLD_YEAR  = 5;

   localparam logic [2:0] ST_RUN       = 3'd0;
   localparam logic [2:0] ST_SET_YEAR  = 3'd1;
   localparam logic [2:0] ST_SET_MONTH = 3'd2;
   localparam logic [2:0] ST_SET_DAY   = 3'd3;
   localparam logic [2:0] ST_SET_HOUR  = 3'd4;
   localparam logic [2:0] ST_SET_MIN   = 3'd5;

   localparam sel_t SEL_NONE  = 3'd0;
   localparam sel_t SEL_YEAR  = 3'd1;
   localparam sel_t SEL_MONTH = 3'd2;
   localparam sel_t SEL_DAY   = 3'd3;
   localparam sel_t SEL_HOUR  = 3'd4;
   localparam sel_t SEL_MIN   = 3'd5;

   localparam logic [5:0] SEC_MAX   = 6'd59;
   localparam logic [5:0] MIN_MAX   = 6'd59;
   localparam logic [4:0] HOUR_MAX  = 5'd23;
   localparam logic [3:0] MONTH_MAX = 4'd12;

   // February holds the common-year length; the leap adjustment lives in cal_days_in_month.
   localparam logic [4:0] DAYS_IN_MONTH [1:12] = '{
      5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
      5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
   };

   function automatic sel_t state_sel(input logic [2:0] st);
      sel_t s;
      s = SEL_NONE;
      case (st)
         ST_SET_YEAR:  s = SEL_YEAR;
         ST_SET_MONTH: s = SEL_MONTH;
         ST_SET_DAY:   s = SEL_DAY;
         ST_SET_HOUR:  s = SEL_HOUR;
         ST_SET_MIN:   s = SEL_MIN;
         default:      s = SEL_NONE;
      endcase
      return s;
   endfunction

   // One-hot field mask of the field edited in a SET state; empty in RUN.
   function automatic fld_vec_t state_field_mask(input logic [2:0] st);
      fld_vec_t m;
      m = '0;
      case (st)
         ST_SET_YEAR:  m[FLD_YEAR]  = 1'b1;
         ST_SET_MONTH: m[FLD_MONTH] = 1'b1;
         ST_SET_DAY:   m[FLD_DAY]   = 1'b1;
         ST_SET_HOUR:  m[FLD_HOUR]  = 1'b1;
         ST_SET_MIN:   m[FLD_MIN]   = 1'b1;
         default:      m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/calendar_ctrl_if.sv
// calendar_ctrl_if: strobes and counter values in, per-field pulses and set-mode status out.
// master = timebase/button front-end side, slave = calendar_ctrl.
interface calendar_ctrl_if;
   import calendar_pkg::*;

   logic        i_tick_1hz;
   logic        i_btn_mode;
   logic        i_btn_inc;
   logic [5:0]  i_sec;
   logic [5:0]  i_min;
   logic [4:0]  i_hour;
   logic [4:0]  i_day;
   logic [3:0]  i_month;
   year_t       i_year;

   fld_vec_t    o_inc;
   fld_vec_t    o_wrap;
   logic        o_set_mode;
   sel_t        o_sel;

   modport master (
      output i_tick_1hz, i_btn_mode, i_btn_inc,
      output i_sec, i_min, i_hour, i_day, i_month, i_year,
      input  o_inc, o_wrap, o_set_mode, o_sel
   );

   modport slave (
      input  i_tick_1hz, i_btn_mode, i_btn_inc,
      input  i_sec, i_min, i_hour, i_day, i_month, i_year,
      output o_inc, o_wrap, o_set_mode, o_sel
   );

endinterface

// File: rtl/cal_days_in_month.sv
// cal_days_in_month: combinational (month, year) -> 28..31.
// CALENDAR_GREGORIAN_EN selects the full Gregorian leap rule; otherwise y%4==0 only (valid 1901..2099).
module cal_days_in_month
   import calendar_pkg::*;
(
   input  logic [3:0] i_month,
   input  year_t      i_year,
   output logic [4:0] o_days
);

   logic leap;

`ifdef CALENDAR_GREGORIAN_EN
   localparam year_t Y100 = 12'd100;
   localparam year_t Y400 = 12'd400;

   assign leap = (i_year[1:0] == 2'b00) &&
                 (((i_year % Y100) != 12'd0) || ((i_year % Y400) == 12'd0));
`else
   // Only the low two bits decide the simplified rule; the rest is intentionally dropped.
   logic unused_year_hi;
   assign unused_year_hi = ^i_year[11:2];
   assign leap = (i_year[1:0] == 2'b00);
`endif

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      o_days = 5'd31;
      if ((i_month >= 4'd1) && (i_month <= MONTH_MAX)) begin
         o_days = DAYS_IN_MONTH[i_month];
      end
      if ((i_month == 4'd2) && leap) begin
         o_days = 5'd29;
      end
   end

endmodule

// File: rtl/calendar_ctrl.sv
// calendar_ctrl: turns the 1 Hz tick into per-field inc/wrap pulses with carry, and runs the
// button-driven set-mode FSM. Leap rule chosen by CALENDAR_GREGORIAN_EN (see cal_days_in_month).
module calendar_ctrl
   import calendar_pkg::*;
#(
   parameter year_t YEAR_BASE = 12'd1970,
   parameter year_t YEAR_MAX  = 12'd2099
)(
   input  logic            i_clk,
   input  logic            i_rst_n,
   calendar_ctrl_if.slave  bus
);

   logic [2:0] state_q, state_d;
   fld_vec_t   inc_q, inc_d;
   fld_vec_t   wrap_q, wrap_d;
   logic       set_mode_q, set_mode_d;
   sel_t       sel_q, sel_d;

   logic [4:0] dim;
   fld_vec_t   at_lim;
   fld_vec_t   carry_in;
   fld_vec_t   set_mask;
   logic       day_over;
   logic       busy;
   logic       tick_ok, mode_ok, inc_ok;

   cal_days_in_month u_dim (
      .i_month (bus.i_month),
      .i_year  (bus.i_year),
      .o_days  (dim)
   );

   // Out-of-range years count as "at limit" so the next step recovers to YEAR_BASE.
   assign at_lim = {
      (bus.i_year  >= YEAR_MAX) || (bus.i_year < YEAR_BASE),
      (bus.i_month >= MONTH_MAX),
      (bus.i_day   >= dim),
      (bus.i_hour  >= HOUR_MAX),
      (bus.i_min   >= MIN_MAX),
      (bus.i_sec   >= SEC_MAX)
   };

   // A field sees the tick only if every lower field wraps.
   assign carry_in = {&at_lim[4:0], &at_lim[3:0], &at_lim[2:0], &at_lim[1:0], at_lim[0], 1'b1};

   assign day_over = (bus.i_day > dim);
   assign set_mask = state_field_mask(state_q);

   // Counters are still updating while a pulse is out, so strobes seen then act on stale values.
   assign busy    = (|inc_q) || (|wrap_q);
   assign mode_ok = bus.i_btn_mode & ~busy;
   assign tick_ok = bus.i_tick_1hz & ~busy;
   assign inc_ok  = bus.i_btn_inc  & ~busy & ~bus.i_btn_mode;

   always_comb begin
      state_d = state_q;
      inc_d   = '0;
      wrap_d  = '0;
      if (mode_ok) begin
         case (state_q)
            ST_RUN:       state_d = ST_SET_YEAR;
            ST_SET_YEAR: begin
               state_d = ST_SET_MONTH;
               wrap_d[FLD_DAY] = day_over;
            end
            ST_SET_MONTH: begin
               state_d = ST_SET_DAY;
               wrap_d[FLD_DAY] = day_over;
            end
            ST_SET_DAY:   state_d = ST_SET_HOUR;
            ST_SET_HOUR:  state_d = ST_SET_MIN;
            ST_SET_MIN: begin
               state_d = ST_RUN;
               wrap_d[FLD_SEC] = 1'b1;
            end
            default:      state_d = ST_RUN;
         endcase
      end else if (state_q == ST_RUN) begin
         if (tick_ok) begin
            inc_d  = carry_in & ~at_lim;
            wrap_d = carry_in &  at_lim;
         end
      end else if (inc_ok) begin
         // SET states step the selected field alone; no carry into neighbours.
         inc_d  = set_mask & ~at_lim;
         wrap_d = set_mask &  at_lim;
      end
      set_mode_d = (state_d != ST_RUN);
      sel_d      = state_sel(state_d);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_RUN;
         inc_q      <= '0;
         wrap_q     <= '0;
         set_mode_q <= 1'b0;
         sel_q      <= SEL_NONE;
      end else begin
         state_q    <= state_d;
         inc_q      <= inc_d;
         wrap_q     <= wrap_d;
         set_mode_q <= set_mode_d;
         sel_q      <= sel_d;
      end
   end

   assign bus.o_inc      = inc_q;
   assign bus.o_wrap     = wrap_q;
   assign bus.o_set_mode = set_mode_q;
   assign bus.o_sel      = sel_q;

   a_inc_wrap_exclusive : assert property (
      @(posedge i_clk) disable iff (!i_rst_n) ((inc_q & wrap_q) == '0)
   );

endmodule
